// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, fetch FSM states and
// the sign-extension helper used by branch and ALU-operand paths.
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int IMM_W  = 16;
    localparam int JTGT_W = 26;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } pc_state_e;

    function automatic logic [XLEN-1:0] sext16to32(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/mips_pc_unit_if.sv
// Fetch control/status bundle between the decoder (master) and the PC unit (slave).
interface mips_pc_unit_if #(
    parameter int CNT_W = 32
);
    import mips_pkg::*;

    logic                stall;
    logic                branch_taken;
    logic [IMM_W-1:0]    branch_imm;
    logic                jump;
    logic [JTGT_W-1:0]   jump_target;
    logic                jump_reg;
    logic [XLEN-1:0]     jr_target;
    logic                halt_req;
    logic [XLEN-1:0]     program_counter;
    logic [XLEN-1:0]     pc_plus1;
    logic                pc_valid;
    logic                halted;
    logic                fault;
    logic [CNT_W-1:0]    retired_count;

    modport master (
        output stall, branch_taken, branch_imm, jump, jump_target,
               jump_reg, jr_target, halt_req,
        input  program_counter, pc_plus1, pc_valid, halted, fault, retired_count
    );

    modport slave (
        input  stall, branch_taken, branch_imm, jump, jump_target,
               jump_reg, jr_target, halt_req,
        output program_counter, pc_plus1, pc_valid, halted, fault, retired_count
    );

endinterface

// File: rtl/mips_next_pc.sv
// Combinational next-PC source select (jr > jump > branch > sequential) and
// instruction-memory range check on the selected target.
module mips_next_pc
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = 256
) (
    input  logic [XLEN-1:0]   pc,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic              jump,
    input  logic [JTGT_W-1:0] jump_target,
    input  logic              jump_reg,
    input  logic [XLEN-1:0]   jr_target,
    output logic [XLEN-1:0]   pc_plus1,
    output logic [XLEN-1:0]   next_pc,
    output logic              out_of_range
);

    always_comb begin
        pc_plus1 = pc + XLEN'(1);
        next_pc  = pc_plus1;
        if (jump_reg) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = {pc_plus1[XLEN-1:JTGT_W], jump_target};
        end else if (branch_taken) begin
            next_pc = pc_plus1 + sext16to32(branch_imm);
        end
        out_of_range = (next_pc >= XLEN'(IMEM_DEPTH));
    end

endmodule

// File: rtl/mips_pc_unit.sv
// Fetch-stage PC unit: BOOT/RUN/HALT/FAULT sequencing, PC register and
// retired-instruction counter; next-PC selection lives in mips_next_pc.
module mips_pc_unit
    import mips_pkg::*;
#(
    parameter int RESET_PC   = 0,
    parameter int IMEM_DEPTH = 256,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    mips_pc_unit_if.slave     pc_if
);

    pc_state_e         state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pc_valid_q, pc_valid_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;

    logic [XLEN-1:0]   pc_plus1;
    logic [XLEN-1:0]   next_pc;
    logic              out_of_range;

    mips_next_pc #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_next_pc (
        .pc           (pc_q),
        .branch_taken (pc_if.branch_taken),
        .branch_imm   (pc_if.branch_imm),
        .jump         (pc_if.jump),
        .jump_target  (pc_if.jump_target),
        .jump_reg     (pc_if.jump_reg),
        .jr_target    (pc_if.jr_target),
        .pc_plus1     (pc_plus1),
        .next_pc      (next_pc),
        .out_of_range (out_of_range)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BOOT: begin
                pc_d    = XLEN'(RESET_PC);
                state_d = RUN;
            end
            RUN: begin
                if (pc_if.halt_req) begin
                    state_d = HALT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (!pc_if.stall) begin
                    // An out-of-range target still retires the instruction that produced it.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (out_of_range) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            HALT:    ;
            FAULT:   ;
            default: state_d = BOOT;
        endcase
        pc_valid_d = (state_d == RUN);
        halted_d   = (state_d == HALT);
        fault_d    = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= XLEN'(RESET_PC);
            cnt_q      <= '0;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            pc_valid_q <= pc_valid_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign pc_if.program_counter = pc_q;
    assign pc_if.pc_plus1        = pc_plus1;
    assign pc_if.pc_valid        = pc_valid_q;
    assign pc_if.halted          = halted_q;
    assign pc_if.fault           = fault_q;
    assign pc_if.retired_count   = cnt_q;

endmodule

// File: tb/tb_mips_pc_unit.sv
// Bench for mips_pc_unit: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the fetch sequencing rules.
module tb_mips_pc_unit;

    localparam int  DEPTH = 256;
    localparam longint MASK32 = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset;

    mips_pc_unit_if #(.CNT_W(32)) pc_if ();

    mips_pc_unit #(
        .RESET_PC   (0),
        .IMEM_DEPTH (DEPTH),
        .CNT_W      (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pc_if (pc_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0=boot, 1=run, 2=halt, 3=fault
    int     m_mode = 0;
    longint m_pc   = 0;
    longint m_cnt  = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, sample outputs 1ns after the edge.
    task automatic cyc(input bit r, input bit s, input bit bt, input logic [15:0] imm,
                       input bit j, input logic [25:0] jt, input bit jr,
                       input logic [31:0] jrt, input bit h);
        longint nxt;
        reset              = r;
        pc_if.stall        = s;
        pc_if.branch_taken = bt;
        pc_if.branch_imm   = imm;
        pc_if.jump         = j;
        pc_if.jump_target  = jt;
        pc_if.jump_reg     = jr;
        pc_if.jr_target    = jrt;
        pc_if.halt_req     = h;
        #1;
        check_eq("pc_plus1_comb", longint'(pc_if.pc_plus1), (m_pc + 1) & MASK32);
        if (r) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (h) begin
                m_mode = 2;
                m_cnt  = (m_cnt + 1) & MASK32;
            end else if (!s) begin
                if (jr)
                    nxt = longint'(jrt);
                else if (j)
                    nxt = (((m_pc + 1) & MASK32) / (longint'(1) << 26)) * (longint'(1) << 26) + longint'(jt);
                else if (bt)
                    nxt = (m_pc + 1 + longint'($signed(imm))) & MASK32;
                else
                    nxt = (m_pc + 1) & MASK32;
                m_cnt = (m_cnt + 1) & MASK32;
                if (nxt >= DEPTH) m_mode = 3;
                else              m_pc   = nxt;
            end
        end
        @(posedge clk);
        #1;
        check_eq("pc",       longint'(pc_if.program_counter), m_pc);
        check_eq("pc_valid", longint'(pc_if.pc_valid),        longint'(m_mode == 1));
        check_eq("halted",   longint'(pc_if.halted),          longint'(m_mode == 2));
        check_eq("fault",    longint'(pc_if.fault),           longint'(m_mode == 3));
        check_eq("retired",  longint'(pc_if.retired_count),   m_cnt);
        $display("cyc t=%0t rst=%0b stall=%0b br=%0b imm=%0h j=%0b jr=%0b jrt=%0d halt=%0b -> pc=%0d cnt=%0d v=%0b h=%0b f=%0b",
                 $time, r, s, bt, imm, j, jr, jrt, h, pc_if.program_counter, pc_if.retired_count,
                 pc_if.pc_valid, pc_if.halted, pc_if.fault);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
    endtask

    task automatic go_to(input logic [31:0] t);
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 1, t, 0);
    endtask

    initial begin
        longint cnt_snap;
        reset = 1'b1;
        pc_if.stall = 0; pc_if.branch_taken = 0; pc_if.branch_imm = 0;
        pc_if.jump = 0; pc_if.jump_target = 0; pc_if.jump_reg = 0;
        pc_if.jr_target = 0; pc_if.halt_req = 0;
        @(posedge clk);
        #1;

        // Reset and free run
        do_reset();
        check_eq("boot_pc", longint'(pc_if.program_counter), 0);
        check_eq("boot_valid", longint'(pc_if.pc_valid), 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            check_eq("run_pc_seq", longint'(pc_if.program_counter), longint'(i));
        end
        check_eq("run_cnt3", longint'(pc_if.retired_count), 3);

        // Branches backward and forward from PC 10
        go_to(32'd10);
        cyc(0, 0, 1, 16'hFFFC, 0, 26'h0, 0, 32'h0, 0);
        check_eq("branch_back", longint'(pc_if.program_counter), 7);
        go_to(32'd10);
        cyc(0, 0, 1, 16'd5, 0, 26'h0, 0, 32'h0, 0);
        check_eq("branch_fwd", longint'(pc_if.program_counter), 16);

        // Jump, alone and with a simultaneous branch
        go_to(32'd20);
        cyc(0, 0, 0, 16'h0, 1, 26'h40, 0, 32'h0, 0);
        check_eq("jump", longint'(pc_if.program_counter), 64);
        go_to(32'd20);
        cyc(0, 0, 1, 16'd3, 1, 26'h40, 0, 32'h0, 0);
        check_eq("jump_over_branch", longint'(pc_if.program_counter), 64);

        // Out-of-range jr faults, PC holds old value
        go_to(32'd5);
        cnt_snap = longint'(pc_if.retired_count);
        go_to(32'd300);
        check_eq("fault_flag", longint'(pc_if.fault), 1);
        check_eq("fault_pc", longint'(pc_if.program_counter), 5);
        check_eq("fault_cnt", longint'(pc_if.retired_count), cnt_snap + 1);
        idle();
        go_to(32'd3);
        check_eq("fault_frozen_pc", longint'(pc_if.program_counter), 5);
        check_eq("fault_frozen_cnt", longint'(pc_if.retired_count), cnt_snap + 1);

        // Stall then halt with stall
        do_reset();
        idle();
        go_to(32'd8);
        cnt_snap = longint'(pc_if.retired_count);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 16'd2, 0, 26'h0, 0, 32'h0, 0);
        check_eq("stall_pc", longint'(pc_if.program_counter), 8);
        check_eq("stall_cnt", longint'(pc_if.retired_count), cnt_snap);
        cyc(0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1);
        check_eq("halt_flag", longint'(pc_if.halted), 1);
        check_eq("halt_cnt", longint'(pc_if.retired_count), cnt_snap + 1);
        idle();
        check_eq("halt_frozen_pc", longint'(pc_if.program_counter), 8);

        // Reset out of HALT
        do_reset();
        check_eq("rst_halted", longint'(pc_if.halted), 0);
        check_eq("rst_pc", longint'(pc_if.program_counter), 0);
        check_eq("rst_cnt", longint'(pc_if.retired_count), 0);
        check_eq("rst_valid", longint'(pc_if.pc_valid), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] imm;
            logic [31:0] jrt;
            if ($urandom_range(0, 3) == 0) imm = 16'($urandom);
            else                           imm = 16'($signed(32'($urandom_range(0, 40)) - 32'sd20));
            jrt = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 300));
            cyc(($urandom_range(0, 39) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 2) == 0),
                imm,
                ($urandom_range(0, 5) == 0),
                26'($urandom_range(0, 300)),
                ($urandom_range(0, 7) == 0),
                jrt,
                ($urandom_range(0, 79) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
